picorv32_trace_fifo: RTL and testbench
======================================

Name: picorv32_trace_fifo

Overview:
- Captures the 36-bit instruction trace stream emitted by the picorv32 core (trace_valid/trace_data) in the simulation wrapper.
- Buffers trace words in a show-ahead FIFO and drains them on a valid/ready interface toward the host/switchboard queue.
- The core has no backpressure on trace, so the block counts and flags words lost to overflow instead of stalling the CPU.

Parameters:
- DEPTH, 64, FIFO entries; power of two, minimum 2.
- DW, 36, trace word width; must match core trace_data width.
- LW, $clog2(DEPTH)+1, width of level output (derived; not overridden).

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- capture_en  input  1  when 0, incoming trace words are ignored; not counted as drops.
- trace_valid  input  1  trace word present this cycle; no ready returned.
- trace_data  input  DW  trace word from core.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head when out_valid && out_ready.
- out_data  output  DW (DW+32 with TRACE_FIFO_TIMESTAMP_EN)  FIFO head word.
- level  output  LW  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: at least one word dropped since reset/clear.
- drop_count  output  16  dropped-word count, saturating.
- clear_stats  input  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset (sampled on posedge clk with reset=1): wr_ptr=rd_ptr=0, level=0, out_valid=0, overflow=0, drop_count=0, timestamp counter=0. out_data is don't-care while out_valid=0. Reset mid-stream discards all buffered words; no partial pop.
- Push condition: push_req = capture_en && trace_valid.
- Pop condition: pop = out_valid && out_ready.
- A push is accepted when level<DEPTH, or when level==DEPTH and pop=1 in the same cycle (simultaneous push/pop at full is legal; level stays DEPTH).
- Drop: push_req && level==DEPTH && !pop. The word is discarded, overflow<=1, and drop_count increments, saturating at 16'hFFFF.
- Storage and pointers:
  - Storage is an array indexed by wr_ptr/rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - level is tracked separately with LW bits; full = level==DEPTH, empty = level==0.
- Level update: +1 on accepted push without pop; -1 on pop without push; unchanged on both or neither.
- Push on empty: the word becomes visible on out_valid/out_data the cycle after trace_valid, i.e. latency 1. No same-cycle bypass.
- Pop on empty cannot occur: out_valid=0.
- Head behaviour:
  - out_data is the storage entry at rd_ptr (show-ahead).
  - out_valid = (level!=0).
  - out_data is stable while out_valid && !out_ready.
- Order: strictly FIFO; accepted words are never reordered or duplicated.
- clear_stats:
  - Sets overflow=0 and drop_count=0 next cycle.
  - If a drop occurs in the same cycle, clear wins; the result is drop_count=0, overflow=0.
  - FIFO contents are unaffected.
- capture_en deassert: already-buffered words keep draining normally.

Optional Feature:
- TRACE_FIFO_TIMESTAMP_EN defined:
  - A free-running 32-bit cycle counter, reset to 0 and wrapping at 2^32, increments every non-reset cycle.
  - On an accepted push, the counter value of that cycle is stored with the word.
  - out_data = {timestamp[31:0], trace[DW-1:0]}, width DW+32.
- Not defined: no counter; out_data width DW; storage DW bits per entry.

Test Plan:
- Basic order: DEPTH=4, out_ready=1, push 36'h1_0000_0001..36'h1_0000_0003 on consecutive cycles -> each appears on out_data one cycle after its push, in order; level never exceeds 1; drop_count=0.
- Fill/overflow: DEPTH=4, out_ready=0, push 6 words A..F -> level=4, A..D retained; drop_count=2, overflow=1; then out_ready=1 -> A,B,C,D drained; out_valid=0 afterwards.
- Full with simultaneous push/pop: DEPTH=4 full with A..D; push E with out_ready=1 -> A popped, E accepted, level stays 4, drop_count unchanged; drain order B,C,D,E.
- Saturation and clear: force 70000 drops -> drop_count=16'hFFFF; clear_stats in the same cycle as a drop -> drop_count=0, overflow=0; buffered data intact.
- Gating/reset: capture_en=0 with trace_valid=1 for 10 cycles -> level=0, drop_count=0. Reset asserted with level=3 -> next cycle out_valid=0, level=0, overflow=0.
- Timestamp (TRACE_FIFO_TIMESTAMP_EN): release reset, push word X at cycle 5 after reset -> out_data[67:36]=5, out_data[35:0]=X.

Source files
------------

// File: rtl/picorv32_trace_fifo.sv
// picorv32_trace_fifo: show-ahead FIFO for the picorv32 trace stream with overflow/drop accounting.
// Define TRACE_FIFO_TIMESTAMP_EN to tag each accepted word with a 32-bit cycle timestamp.
module picorv32_trace_fifo #(
   parameter int DEPTH = 64,
   parameter int DW = 36,
   localparam int LW = $clog2(DEPTH) + 1,
`ifdef TRACE_FIFO_TIMESTAMP_EN
   localparam int OW = DW + 32
`else
   localparam int OW = DW
`endif
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          capture_en,
   input  logic          trace_valid,
   input  logic [DW-1:0] trace_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic [LW-1:0] level,
   output logic          overflow,
   output logic [15:0]   drop_count,
   input  logic          clear_stats
);
   localparam int AW = $clog2(DEPTH);
   logic [OW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [OW-1:0] wdata;
   logic push_req, pop, full, push, drop;
   assign push_req = capture_en && trace_valid;
   assign pop = out_valid && out_ready;
   assign full = level == LW'(DEPTH);
   // at full a push is still taken when the head leaves in the same cycle
   assign push = push_req && (!full || pop);
   assign drop = push_req && full && !pop;
   assign out_valid = level != '0;
   assign out_data = mem[rd_ptr];
`ifdef TRACE_FIFO_TIMESTAMP_EN
   logic [31:0] ts;
   always_ff @(posedge clk) ts <= reset ? 32'd0 : ts + 32'd1;
   assign wdata = {ts, trace_data};
`else
   assign wdata = trace_data;
`endif
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wdata;
   always_ff @(posedge clk)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
         overflow <= 1'b0;
         drop_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         level <= (push && !pop) ? level + LW'(1) : (pop && !push) ? level - LW'(1) : level;
         overflow <= clear_stats ? 1'b0 : overflow | drop;
         drop_count <= clear_stats ? 16'd0 : (drop && drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
      end
endmodule

// File: tb/tb_picorv32_trace_fifo.sv
// tb_picorv32_trace_fifo: table vectors, corner sequences and random traffic against a queue model.
module tb_picorv32_trace_fifo;
   localparam int DEPTH = 4;
   localparam int DW = 36;
   localparam int LW = 3;
`ifdef TRACE_FIFO_TIMESTAMP_EN
   localparam int OW = DW + 32;
`else
   localparam int OW = DW;
`endif
   localparam logic [DW-1:0] W1 = 36'h1_0000_0001, W2 = 36'h1_0000_0002, W3 = 36'h1_0000_0003;
   localparam logic [DW-1:0] WA = 36'hA_0000_000A, WB = 36'hB_0000_000B, WC = 36'hC_0000_000C;
   localparam logic [DW-1:0] WD = 36'hD_0000_000D, WE = 36'hE_0000_000E, WF = 36'hF_0000_000F;

   logic clk = 1'b0, reset, capture_en, trace_valid, out_valid, out_ready, overflow, clear_stats;
   logic [DW-1:0] trace_data;
   logic [OW-1:0] out_data;
   logic [LW-1:0] level;
   logic [15:0] drop_count;
   int tests = 0, fails = 0;

   logic [OW-1:0] q[$];
   int m_dc;
   bit m_ov;
   logic [31:0] m_ts;

   typedef struct {
      logic rst, ce, tv;
      logic [DW-1:0] d;
      logic rdy, clr, e_valid;
      int e_level;
      logic [DW-1:0] e_head;
      logic e_ov;
      int e_dc;
   } vec_t;
   vec_t vecs[$];

   picorv32_trace_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .reset(reset), .capture_en(capture_en), .trace_valid(trace_valid),
      .trace_data(trace_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level), .overflow(overflow), .drop_count(drop_count), .clear_stats(clear_stats)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   // Reference: an unbounded queue capped at DEPTH, with drop/clear bookkeeping.
   task automatic model(input logic rst, ce, tv, input logic [DW-1:0] d, input logic rdy, clr);
      bit req, pop, full;
      logic [OW-1:0] w;
      if (rst) begin
         q.delete();
         m_dc = 0;
         m_ov = 0;
         m_ts = 0;
         return;
      end
`ifdef TRACE_FIFO_TIMESTAMP_EN
      w = {m_ts, d};
`else
      w = d;
`endif
      req = ce && tv;
      full = q.size() == DEPTH;
      pop = q.size() != 0 && rdy;
      if (pop) void'(q.pop_front());
      if (req && (!full || pop)) q.push_back(w);
      if (clr) begin
         m_dc = 0;
         m_ov = 0;
      end else if (req && full && !pop) begin
         m_ov = 1;
         if (m_dc < 65535) m_dc++;
      end
      m_ts = m_ts + 32'd1;
   endtask

   task automatic step(input logic rst, ce, tv, input logic [DW-1:0] d, input logic rdy, clr);
      reset = rst;
      capture_en = ce;
      trace_valid = tv;
      trace_data = d;
      out_ready = rdy;
      clear_stats = clr;
      @(posedge clk);
      model(rst, ce, tv, d, rdy, clr);
      #1;
      chk("out_valid", out_valid, q.size() != 0);
      chk("level", level, q.size());
      chk("overflow", overflow, m_ov);
      chk("drop_count", drop_count, m_dc);
      if (q.size() != 0) chk("out_data", out_data, q[0]);
   endtask

   function automatic void add(input logic rst, ce, tv, input logic [DW-1:0] d, input logic rdy, clr,
                               input logic ev, input int el, input logic [DW-1:0] eh, input logic eo, input int ed);
      vecs.push_back('{rst, ce, tv, d, rdy, clr, ev, el, eh, eo, ed});
   endfunction

   initial begin
      logic [DW-1:0] exp_seq [4];
      int bias;
      // basic order with out_ready held high
      add(1, 0, 0, '0, 1, 0, 0, 0, '0, 0, 0);
      add(0, 1, 1, W1, 1, 0, 1, 1, W1, 0, 0);
      add(0, 1, 1, W2, 1, 0, 1, 1, W2, 0, 0);
      add(0, 1, 1, W3, 1, 0, 1, 1, W3, 0, 0);
      add(0, 0, 0, '0, 1, 0, 0, 0, '0, 0, 0);
      // fill past full, then drain
      add(1, 0, 0, '0, 0, 0, 0, 0, '0, 0, 0);
      add(0, 1, 1, WA, 0, 0, 1, 1, WA, 0, 0);
      add(0, 1, 1, WB, 0, 0, 1, 2, WA, 0, 0);
      add(0, 1, 1, WC, 0, 0, 1, 3, WA, 0, 0);
      add(0, 1, 1, WD, 0, 0, 1, 4, WA, 0, 0);
      add(0, 1, 1, WE, 0, 0, 1, 4, WA, 1, 1);
      add(0, 1, 1, WF, 0, 0, 1, 4, WA, 1, 2);
      add(0, 0, 0, '0, 1, 0, 1, 3, WB, 1, 2);
      add(0, 0, 0, '0, 1, 0, 1, 2, WC, 1, 2);
      add(0, 0, 0, '0, 1, 0, 1, 1, WD, 1, 2);
      add(0, 0, 0, '0, 1, 0, 0, 0, '0, 1, 2);
      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].ce, vecs[i].tv, vecs[i].d, vecs[i].rdy, vecs[i].clr);
         chk("tbl_valid", out_valid, vecs[i].e_valid);
         chk("tbl_level", level, vecs[i].e_level);
         chk("tbl_overflow", overflow, vecs[i].e_ov);
         chk("tbl_drop_count", drop_count, vecs[i].e_dc);
         if (vecs[i].e_valid) chk("tbl_head", out_data[DW-1:0], vecs[i].e_head);
      end

      // full with simultaneous push and pop
      step(1, 0, 0, '0, 0, 0);
      step(0, 1, 1, WA, 0, 0);
      step(0, 1, 1, WB, 0, 0);
      step(0, 1, 1, WC, 0, 0);
      step(0, 1, 1, WD, 0, 0);
      step(0, 1, 1, WE, 1, 0);
      chk("pp_level", level, 4);
      chk("pp_drop_count", drop_count, 0);
      exp_seq = '{WB, WC, WD, WE};
      for (int i = 0; i < 4; i++) begin
         chk("pp_drain", out_data[DW-1:0], exp_seq[i]);
         step(0, 0, 0, '0, 1, 0);
      end
      chk("pp_empty", out_valid, 0);

      // capture gating
      step(1, 0, 0, '0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 1, DW'($urandom), 0, 0);
      chk("gate_level", level, 0);
      chk("gate_drop_count", drop_count, 0);

      // reset with buffered words and a sticky overflow
      for (int i = 0; i < 5; i++) step(0, 1, 1, DW'(i + 100), 0, 0);
      step(0, 0, 0, '0, 1, 0);
      chk("prerst_level", level, 3);
      chk("prerst_overflow", overflow, 1);
      step(1, 0, 0, '0, 1, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);

      // drop counter saturation, then clear racing a drop
      for (int i = 0; i < 4; i++) step(0, 1, 1, 36'h5_0000_0000 + DW'(i), 0, 0);
      for (int i = 0; i < 70000; i++) step(0, 1, 1, DW'($urandom), 0, 0);
      chk("sat_drop_count", drop_count, 16'hFFFF);
      chk("sat_overflow", overflow, 1);
      step(0, 1, 1, DW'($urandom), 0, 1);
      chk("clr_drop_count", drop_count, 0);
      chk("clr_overflow", overflow, 0);
      chk("clr_level", level, 4);
      for (int i = 0; i < 4; i++) begin
         chk("clr_data", out_data[DW-1:0], 36'h5_0000_0000 + DW'(i));
         step(0, 0, 0, '0, 1, 0);
      end

`ifdef TRACE_FIFO_TIMESTAMP_EN
      step(1, 0, 0, '0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 0, 0);
      step(0, 1, 1, 36'h7_1234_5678, 0, 0);
      chk("ts_stamp", out_data[DW+31:DW], 5);
      chk("ts_word", out_data[DW-1:0], 36'h7_1234_5678);
`endif

      // random traffic with slowly varying consumer pressure
      bias = 2;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) bias = $urandom_range(0, 4);
         step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
              DW'({$urandom, $urandom}), $urandom_range(0, 3) < bias, $urandom_range(0, 59) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
